// File: rtl/result_writeback_pkg.sv
// Shared types for the result writeback path: the buffered result record
// and the GPR one-hot decode used to build the pending-write mask.
package Writeback_types;

  localparam int GPR_COUNT = 32;

  typedef struct packed {
    logic        gpr_we;
    logic [4:0]  gpr_addr;
    logic [31:0] gpr_data;
    logic        cr_we;
    logic [31:0] cr;
  } Wb_record;

  function automatic logic [GPR_COUNT-1:0] decode_gpr(input logic [4:0] addr);
    logic [GPR_COUNT-1:0] mask;
    mask       = {GPR_COUNT{1'b0}};
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/result_writeback_fifo.sv
// Per-source result buffer. Besides head/count/full/empty it exposes the
// GPR targets of its live entries so the top can build the pending mask.
module Wb_fifo
  import Writeback_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  Wb_record                       din,
  input  logic                           pop,
  output Wb_record                       head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic [GPR_COUNT-1:0]           pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  Wb_record             mem_r [DEPTH];
  logic [DEPTH-1:0]     valid_r;
  logic [DEPTH-1:0]     valid_s;
  logic [PW-1:0]        rd_ptr_r;
  logic [PW-1:0]        wr_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : ptr + PW'(1);
  endfunction

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Per-entry liveness tracks push/pop so the pending mask needs no pointer math.
  always_comb begin
    valid_s = valid_r;
    if (pop_ok_s) begin
      valid_s[rd_ptr_r] = 1'b0;
    end else begin
      valid_s = valid_s;
    end
    if (push_ok_s) begin
      valid_s[wr_ptr_r] = 1'b1;
    end else begin
      valid_s = valid_s;
    end
  end

  // Pointers, count and liveness bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= {DEPTH{1'b0}};
    end else begin
      valid_r <= valid_s;
      if (push_ok_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Record storage; contents are meaningless unless the entry is live.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  // OR of GPR targets over live entries.
  always_comb begin
    pending = {GPR_COUNT{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      pending = pending |
                ((valid_r[i] && mem_r[i].gpr_we) ? decode_gpr(mem_r[i].gpr_addr)
                                                 : {GPR_COUNT{1'b0}});
    end
  end

endmodule

// File: rtl/result_writeback.sv
// Collects functional-unit results into per-source buffers, retires them
// round-robin through one registered GPR/CR write port, and reports pending GPRs.
module result_writeback
  import Writeback_types::*;
#(
  parameter int N_SRC = 2,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     res_valid,
  output logic [N_SRC-1:0]     res_ready,
  input  logic [N_SRC-1:0]     res_gpr_we,
  input  logic [N_SRC*5-1:0]   res_gpr_addr,
  input  logic [N_SRC*32-1:0]  res_gpr_data,
  input  logic [N_SRC-1:0]     res_cr_we,
  input  logic [N_SRC*32-1:0]  res_cr,
  output logic                 gpr_we,
  output logic [4:0]           gpr_addr,
  output logic [31:0]          gpr_data,
  output logic                 cr_we,
  output logic [31:0]          cr,
  output logic [31:0]          gpr_pending
);

  localparam int RW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  Wb_record               head_s [N_SRC];
  logic [CW-1:0]          count_s [N_SRC];
  logic [GPR_COUNT-1:0]   fifo_pending_s [N_SRC];
  logic [N_SRC-1:0]       full_s;
  logic [N_SRC-1:0]       empty_s;
  logic [N_SRC-1:0]       push_s;
  logic [N_SRC-1:0]       pop_s;
  logic [RW-1:0]          rr_ptr_r;
  logic [RW-1:0]          win_s;
  logic                   grant_s;
  Wb_record               sel_s;

  for (genvar s = 0; s < N_SRC; s++) begin : g_src
    Wb_record rec_s;
    assign rec_s = '{gpr_we:   res_gpr_we[s],
                     gpr_addr: res_gpr_addr[s*5 +: 5],
                     gpr_data: res_gpr_data[s*32 +: 32],
                     cr_we:    res_cr_we[s],
                     cr:       res_cr[s*32 +: 32]};
    // Records with no write enable are accepted but never occupy a slot.
    assign push_s[s]    = res_valid[s] & ~full_s[s] & (res_gpr_we[s] | res_cr_we[s]);
    assign res_ready[s] = (count_s[s] != CW'(DEPTH));
    assign pop_s[s]     = grant_s & (win_s == RW'(s));

    Wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_s[s]),
      .din     (rec_s),
      .pop     (pop_s[s]),
      .head    (head_s[s]),
      .count   (count_s[s]),
      .full    (full_s[s]),
      .empty   (empty_s[s]),
      .pending (fifo_pending_s[s])
    );
  end

  // First non-empty source at or after rr_ptr, searched cyclically.
  always_comb begin
    int idx;
    grant_s = 1'b0;
    win_s   = {RW{1'b0}};
    idx     = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(rr_ptr_r) + k) % N_SRC;
      if (!grant_s && !empty_s[idx]) begin
        grant_s = 1'b1;
        win_s   = RW'(idx);
      end else begin
        grant_s = grant_s;
      end
    end
  end

  assign sel_s = head_s[win_s];

  // Round-robin pointer advances past the winner only on a grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r <= {RW{1'b0}};
    end else if (grant_s) begin
      rr_ptr_r <= RW'((int'(win_s) + 1) % N_SRC);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Output stage: enables pulse per grant, address/data hold between grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpr_we   <= 1'b0;
      gpr_addr <= 5'd0;
      gpr_data <= 32'd0;
      cr_we    <= 1'b0;
      cr       <= 32'd0;
    end else if (grant_s) begin
      gpr_we   <= sel_s.gpr_we;
      gpr_addr <= sel_s.gpr_addr;
      gpr_data <= sel_s.gpr_data;
      cr_we    <= sel_s.cr_we;
      cr       <= sel_s.cr;
    end else begin
      gpr_we   <= 1'b0;
      cr_we    <= 1'b0;
    end
  end

  // Pending mask covers buffered entries plus the staged write.
  always_comb begin
    gpr_pending = gpr_we ? decode_gpr(gpr_addr) : 32'd0;
    for (int s = 0; s < N_SRC; s++) begin
      gpr_pending = gpr_pending | fifo_pending_s[s];
    end
  end

endmodule
